// File: rtl/inst_fetch_sramlike.sv
// inst_fetch_sramlike
// Instruction-fetch stage for the sram-like MIPS core. Keeps the fetch PC,
// issues one instruction read at a time on the sram-like port, and feeds the
// IF/ID register. A one-entry skid buffer absorbs a response that arrives
// while decode is stalled. Redirects discard in-flight data, and a misaligned
// PC raises an address error.
//
// Ports:
//   clk, resetn             clock (rising edge), async active-low reset
//   inst_req/wr/size/addr/wdata   request side of the sram-like port
//   inst_addr_ok            request accepted this cycle
//   inst_data_ok/rdata      read response
//   stallD, flushD          decode hold / invalidate of the IF/ID register
//   redirect, redirect_pc   load a new fetch PC
//   instrD, pcD, validD, adelD    IF/ID register outputs
module inst_fetch_sramlike #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        adelD
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_pend_q, pc_pend_d;
  logic        discard_q, discard_d;
  logic        sk_v_q, sk_v_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        valid_d_q, valid_d_d;
  logic        adel_d_q, adel_d_d;

  logic accept;
  logic id_can_load;

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'h0;
  assign inst_addr  = pc_f_q;
  assign instrD     = instr_d_q;
  assign pcD        = pc_d_q;
  assign validD     = valid_d_q;
  assign adelD      = adel_d_q;

  assign accept = inst_req && inst_addr_ok;
  // flushD outranks any load, so a flushed cycle never fills ID.
  assign id_can_load = (!valid_d_q || !stallD) && !flushD;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_REQ;
      pc_f_q     <= RESET_PC;
      pc_pend_q  <= 32'h0;
      discard_q  <= 1'b0;
      sk_v_q     <= 1'b0;
      sk_instr_q <= 32'h0;
      sk_pc_q    <= 32'h0;
      instr_d_q  <= 32'h0;
      pc_d_q     <= 32'h0;
      valid_d_q  <= 1'b0;
      adel_d_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      pc_pend_q  <= pc_pend_d;
      discard_q  <= discard_d;
      sk_v_q     <= sk_v_d;
      sk_instr_q <= sk_instr_d;
      sk_pc_q    <= sk_pc_d;
      instr_d_q  <= instr_d_d;
      pc_d_q     <= pc_d_d;
      valid_d_q  <= valid_d_d;
      adel_d_q   <= adel_d_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    pc_pend_d  = pc_pend_q;
    discard_d  = discard_q;
    sk_v_d     = sk_v_q;
    sk_instr_d = sk_instr_q;
    sk_pc_d    = sk_pc_q;
    instr_d_d  = instr_d_q;
    pc_d_d     = pc_d_q;
    valid_d_d  = valid_d_q;
    adel_d_d   = adel_d_q;

    // A buffered instruction always drains into ID before new data.
    if (id_can_load && sk_v_q) begin
      instr_d_d = sk_instr_q;
      pc_d_d    = sk_pc_q;
      valid_d_d = 1'b1;
      adel_d_d  = 1'b0;
      sk_v_d    = 1'b0;
    end

    if (redirect) begin
      pc_f_d = redirect_pc;
      sk_v_d = 1'b0;
      if (state_q == S_WAIT && inst_data_ok) begin
        // The response completes now; drop it, nothing left to discard.
        discard_d = 1'b0;
        state_d   = S_REQ;
      end else if (state_q == S_WAIT || accept) begin
        // A stale response is still coming back and must be swallowed.
        if (accept) begin
          pc_pend_d = pc_f_q;
        end
        discard_d = 1'b1;
        state_d   = S_WAIT;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            pc_pend_d = pc_f_q;
            pc_f_d    = pc_f_q + 32'd4;
            state_d   = S_WAIT;
          end else if (pc_f_q[1:0] != 2'b00 && !sk_v_q && id_can_load) begin
            instr_d_d = 32'h0;
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b1;
            adel_d_d  = 1'b1;
            state_d   = S_ERR;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            state_d = S_REQ;
            if (discard_q) begin
              discard_d = 1'b0;
            end else if (id_can_load && !sk_v_q) begin
              instr_d_d = inst_rdata;
              pc_d_d    = pc_pend_q;
              valid_d_d = 1'b1;
              adel_d_d  = 1'b0;
            end else begin
              sk_v_d     = 1'b1;
              sk_instr_d = inst_rdata;
              sk_pc_d    = pc_pend_q;
            end
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end

    if (flushD) begin
      valid_d_d = 1'b0;
      adel_d_d  = 1'b0;
    end
  end

  // Requests depend only on registered state; reset masks them directly.
  always_comb begin
    inst_req = 1'b0;
    if (resetn && state_q == S_REQ && !sk_v_q && pc_f_q[1:0] == 2'b00) begin
      inst_req = 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_sramlike.sv
// Testbench for inst_fetch_sramlike: per-cycle vector table describing the
// bus/decode inputs and the outputs expected during that cycle, followed by
// hand-written sequences for redirect-with-data and mid-transaction reset.
module tb_inst_fetch_sramlike;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        stallD;
  logic        flushD;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        adelD;

  int vectors_applied;
  int miscompares;

  localparam logic [31:0] I0 = 32'h2401_0000;
  localparam logic [31:0] I1 = 32'h2401_0001;
  localparam logic [31:0] I2 = 32'h2401_0002;
  localparam logic [31:0] I3 = 32'h2401_0003;
  localparam logic [31:0] I4 = 32'h2401_0004;
  localparam logic [31:0] I5 = 32'h2401_0005;
  localparam logic [31:0] I6 = 32'h2401_0006;
  localparam logic [31:0] I7 = 32'h2401_0007;
  localparam logic [31:0] I8 = 32'h2401_0008;
  localparam logic [31:0] I9 = 32'h2401_0009;

  typedef struct {
    logic        ao;
    logic        dok;
    logic [31:0] rdata;
    logic        stall;
    logic        flush;
    logic        rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pcd;
    logic [31:0] ins;
    logic        adel;
  } vec_t;

  vec_t vecs[32];

  inst_fetch_sramlike #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .stallD       (stallD),
    .flushD       (flushD),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instrD       (instrD),
    .pcD          (pcD),
    .validD       (validD),
    .adelD        (adelD)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic ao, input logic dok, input logic [31:0] rdata,
                              input logic stall, input logic flush, input logic rd,
                              input logic [31:0] rpc, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pcd, input logic [31:0] ins,
                              input logic adel);
    vec_t v;
    v.ao = ao; v.dok = dok; v.rdata = rdata; v.stall = stall; v.flush = flush;
    v.rd = rd; v.rpc = rpc; v.req = req; v.addr = addr; v.vld = vld;
    v.pcd = pcd; v.ins = ins; v.adel = adel;
    return v;
  endfunction

  task automatic checkField(input string tag, input string name,
                            input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // Drives one cycle's inputs right after the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    inst_addr_ok = v.ao;
    inst_data_ok = v.dok;
    inst_rdata   = v.rdata;
    stallD       = v.stall;
    flushD       = v.flush;
    redirect     = v.rd;
    redirect_pc  = v.rpc;
  endtask

  // Samples all outputs mid-cycle, well away from the rising edge.
  task automatic checkOutput(input vec_t v, input string tag);
    #1;
    vectors_applied++;
    checkField(tag, "inst_req", {31'h0, inst_req}, {31'h0, v.req});
    checkField(tag, "inst_addr", inst_addr, v.addr);
    checkField(tag, "validD", {31'h0, validD}, {31'h0, v.vld});
    checkField(tag, "pcD", pcD, v.pcd);
    checkField(tag, "instrD", instrD, v.ins);
    checkField(tag, "adelD", {31'h0, adelD}, {31'h0, v.adel});
    checkField(tag, "inst_wr", {31'h0, inst_wr}, 32'h0);
    checkField(tag, "inst_size", {30'h0, inst_size}, 32'h2);
    checkField(tag, "inst_wdata", inst_wdata, 32'h0);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  // Main sequence plus corner-case sequences.
  initial begin
    vec_t idle;
    vec_t rst_exp;
    vec_t h;
    bit   seen;

    vectors_applied = 0;
    miscompares     = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    stallD = 0; flushD = 0; redirect = 0; redirect_pc = 0;
    resetn = 1'b1;

    idle    = mk(0,0,0,0,0,0,0, 0,32'h0,0,0,0,0);
    rst_exp = mk(0,0,0,0,0,0,0, 0,32'hBFC00000,0,0,0,0);

    // Zero-wait fetch, stall with skid, redirects, flush, address error, wrap.
    vecs[0]  = mk(1,0,0, 0,0,0,0,            1,32'hBFC00000,0,32'h0,32'h0,0);
    vecs[1]  = mk(0,1,I0,0,0,0,0,            0,32'hBFC00004,0,32'h0,32'h0,0);
    vecs[2]  = mk(1,0,0, 0,0,0,0,            1,32'hBFC00004,1,32'hBFC00000,I0,0);
    vecs[3]  = mk(0,1,I1,0,0,0,0,            0,32'hBFC00008,1,32'hBFC00000,I0,0);
    vecs[4]  = mk(1,0,0, 0,0,0,0,            1,32'hBFC00008,1,32'hBFC00004,I1,0);
    vecs[5]  = mk(0,1,I2,0,0,0,0,            0,32'hBFC0000C,1,32'hBFC00004,I1,0);
    vecs[6]  = mk(1,0,0, 1,0,0,0,            1,32'hBFC0000C,1,32'hBFC00008,I2,0);
    vecs[7]  = mk(0,1,I3,1,0,0,0,            0,32'hBFC00010,1,32'hBFC00008,I2,0);
    vecs[8]  = mk(0,0,0, 1,0,0,0,            0,32'hBFC00010,1,32'hBFC00008,I2,0);
    vecs[9]  = mk(0,0,0, 1,0,0,0,            0,32'hBFC00010,1,32'hBFC00008,I2,0);
    vecs[10] = mk(0,0,0, 1,0,0,0,            0,32'hBFC00010,1,32'hBFC00008,I2,0);
    vecs[11] = mk(0,0,0, 0,0,0,0,            0,32'hBFC00010,1,32'hBFC00008,I2,0);
    vecs[12] = mk(1,0,0, 0,0,0,0,            1,32'hBFC00010,1,32'hBFC0000C,I3,0);
    vecs[13] = mk(0,1,I4,0,0,0,0,            0,32'hBFC00014,1,32'hBFC0000C,I3,0);
    vecs[14] = mk(1,0,0, 0,0,0,0,            1,32'hBFC00014,1,32'hBFC00010,I4,0);
    vecs[15] = mk(0,0,0, 0,0,1,32'h80000180, 0,32'hBFC00018,1,32'hBFC00010,I4,0);
    vecs[16] = mk(0,1,I5,0,0,0,0,            0,32'h80000180,1,32'hBFC00010,I4,0);
    vecs[17] = mk(1,0,0, 0,0,1,32'h80000200, 1,32'h80000180,1,32'hBFC00010,I4,0);
    vecs[18] = mk(0,1,I6,0,0,0,0,            0,32'h80000200,1,32'hBFC00010,I4,0);
    vecs[19] = mk(1,0,0, 0,0,0,0,            1,32'h80000200,1,32'hBFC00010,I4,0);
    vecs[20] = mk(0,1,I7,0,1,0,0,            0,32'h80000204,1,32'hBFC00010,I4,0);
    vecs[21] = mk(0,0,0, 0,0,0,0,            0,32'h80000204,0,32'hBFC00010,I4,0);
    vecs[22] = mk(0,0,0, 0,0,1,32'hBFC00002, 1,32'h80000204,1,32'h80000200,I7,0);
    vecs[23] = mk(0,0,0, 0,0,0,0,            0,32'hBFC00002,1,32'h80000200,I7,0);
    vecs[24] = mk(0,0,0, 0,0,0,0,            0,32'hBFC00002,1,32'hBFC00002,32'h0,1);
    vecs[25] = mk(0,0,0, 0,0,1,32'hBFC00100, 0,32'hBFC00002,1,32'hBFC00002,32'h0,1);
    vecs[26] = mk(1,0,0, 0,0,0,0,            1,32'hBFC00100,1,32'hBFC00002,32'h0,1);
    vecs[27] = mk(0,1,I8,0,0,0,0,            0,32'hBFC00104,1,32'hBFC00002,32'h0,1);
    vecs[28] = mk(0,0,0, 0,0,1,32'hFFFFFFFC, 1,32'hBFC00104,1,32'hBFC00100,I8,0);
    vecs[29] = mk(1,0,0, 0,0,0,0,            1,32'hFFFFFFFC,1,32'hBFC00100,I8,0);
    vecs[30] = mk(0,1,I9,0,0,0,0,            0,32'h00000000,1,32'hBFC00100,I8,0);
    vecs[31] = mk(0,0,0, 0,0,0,0,            1,32'h00000000,1,32'hFFFFFFFC,I9,0);

    #2 resetn = 1'b0;
    @(negedge clk);
    checkOutput(rst_exp, "reset");
    @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    vectors_applied++;
    checkField("release", "inst_req", {31'h0, inst_req}, 32'h1);

    for (int i = 0; i < 32; i++) begin
      runVector(vecs[i], $sformatf("c%0d", i));
    end

    // Fresh reset before the corner-case sequences.
    applyStimulus(idle);
    #3 resetn = 1'b0;
    checkOutput(rst_exp, "reset2");
    @(posedge clk);
    #2 resetn = 1'b1;

    // Redirect coinciding with data_ok: data dropped, next response kept.
    h = mk(1,0,0,0,0,0,0, 1,32'hBFC00000,0,0,0,0);
    runVector(h, "h0");
    h = mk(0,1,32'hDEADBEEF,0,0,1,32'h80000000, 0,32'hBFC00004,0,0,0,0);
    runVector(h, "h1");
    h = mk(1,0,0,0,0,0,0, 1,32'h80000000,0,0,0,0);
    runVector(h, "h2");
    h = mk(0,1,32'hAAAA5555,0,0,0,0, 0,32'h80000004,0,0,0,0);
    runVector(h, "h3");
    h = mk(1,0,0,0,0,0,0, 1,32'h80000004,1,32'h80000000,32'hAAAA5555,0);
    runVector(h, "h4");

    // Reset while a transaction is outstanding clears everything at once.
    applyStimulus(idle);
    #3 resetn = 1'b0;
    checkOutput(rst_exp, "midreset");
    @(posedge clk);
    #2 resetn = 1'b1;

    // Bounded wait for the first request after release.
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (inst_req) seen = 1'b1;
    end
    vectors_applied++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL postreset_req: got no inst_req within 4 cycles, expected one");
    end else begin
      checkField("postreset", "inst_addr", inst_addr, 32'hBFC00000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
